// File: rtl/serial_bus_arbiter_if.sv
// serial_bus_arbiter_if: requester handshake plus serial master bus of the arbiter
interface serial_bus_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        REQ;
    logic [NUM_REQ*ADDR_W-1:0] REQ_ADDR;
    logic [NUM_REQ-1:0]        GNT;
    logic [NUM_REQ-1:0]        DONE;
    logic [DATA_W-1:0]         RD_DATA;
    logic                      BUSY;
    logic                      SCLK;
    logic                      TX;
    logic                      RX;
    modport master (input REQ, REQ_ADDR, RX, output GNT, DONE, RD_DATA, BUSY, SCLK, TX);
    modport slave (output REQ, REQ_ADDR, RX, input GNT, DONE, RD_DATA, BUSY, SCLK, TX);
endinterface

// File: rtl/serial_bus_arbiter.sv
// serial_bus_arbiter: round-robin sharing of one serial master port, address out then data in
module serial_bus_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CLK_DIV = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8
) (
    input logic CLK,
    input logic RST,
    serial_bus_arbiter_if.master bus
);
    localparam int PW   = $clog2(NUM_REQ);
    localparam int DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int MAXW = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int BW   = $clog2(MAXW + 1);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, FIN} state_t;
    state_t            state;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     win;
    logic [PW-1:0]     idx;
    logic [ADDR_W-1:0] addr_sel;
    logic [DW-1:0]     div;
    logic [BW-1:0]     bitc;
    logic [ADDR_W-1:0] ash;
    logic [DATA_W-1:0] dsh;
    logic [DATA_W-1:0] data_next;
    logic              phase_end;
    logic              bit_end;
    logic              last_bit;
    assign phase_end = div == DW'(CLK_DIV - 1);
    assign bit_end   = phase_end && bus.SCLK;
    assign last_bit  = bitc == BW'((state == ADDR ? ADDR_W : DATA_W) - 1);
    assign data_next = (dsh >> 1) | {bus.RX, {(DATA_W-1){1'b0}}};
    // round-robin winner: lowest offset from ptr wins, wrapping at NUM_REQ; also select its address
    always_comb begin
        win = ptr;
        idx = '0;
        addr_sel = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i >= NUM_REQ) ? PW'(int'(ptr) + i - NUM_REQ) : PW'(int'(ptr) + i);
            if (bus.REQ[idx]) win = idx;
        end
        for (int k = 0; k < NUM_REQ; k++)
            if (win == PW'(k)) addr_sel = bus.REQ_ADDR[k*ADDR_W +: ADDR_W];
    end
    // transaction sequencer: arbitration, SCLK timing, shifting and the registered handshake outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            ptr         <= '0;
            div         <= '0;
            bitc        <= '0;
            ash         <= '0;
            dsh         <= '0;
            bus.GNT     <= '0;
            bus.DONE    <= '0;
            bus.RD_DATA <= '0;
            bus.BUSY    <= 1'b0;
            bus.SCLK    <= 1'b0;
            bus.TX      <= 1'b0;
        end else begin
            bus.DONE <= '0;
            case (state)
                IDLE: if (|bus.REQ) begin
                    bus.GNT  <= NUM_REQ'(1) << win;
                    ash      <= addr_sel;
                    bus.TX   <= addr_sel[0];
                    bus.BUSY <= 1'b1;
                    bus.SCLK <= 1'b0;
                    div      <= '0;
                    bitc     <= '0;
                    ptr      <= (win == PW'(NUM_REQ - 1)) ? '0 : win + PW'(1);
                    state    <= ADDR;
                end
                ADDR, DATA: begin
                    div <= phase_end ? '0 : div + DW'(1);
                    if (phase_end) bus.SCLK <= ~bus.SCLK;
                    if (bit_end) begin
                        bitc <= last_bit ? '0 : bitc + BW'(1);
                        if (state == ADDR) begin
                            ash    <= ash >> 1;
                            bus.TX <= last_bit ? 1'b0 : ash[1];
                            if (last_bit) state <= DATA;
                        end else begin
                            dsh <= data_next;
                            if (last_bit) begin
                                bus.DONE    <= bus.GNT;
                                bus.RD_DATA <= data_next;
                                state       <= FIN;
                            end
                        end
                    end
                end
                FIN: begin
                    bus.GNT  <= '0;
                    bus.BUSY <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_bus_arbiter.sv
// tb_serial_bus_arbiter: randomized scoreboard bench with slave models for CLK_DIV=4 and CLK_DIV=1
module tb_serial_bus_arbiter;
    localparam int LAT0 = 128;
    localparam int LAT1 = 32;
    typedef struct {
        int         d;
        int         idx;
        logic [7:0] a;
        logic [7:0] v;
        bit         b2b;
    } exp_t;
    logic CLK = 1'b0;
    logic RST = 1'b0;
    int ntests = 0;
    int nfail = 0;
    int cyc = 0;
    exp_t q[$];
    logic [7:0] resp [256];
    logic [7:0] cap0 = '0;
    logic [7:0] cap1 = '0;
    int k0 = 0;
    int k1 = 0;
    int mptr [2] = '{0, 0};
    int last_done [2] = '{0, 0};
    int gstart [2] = '{0, 0};
    logic [7:0] last_rd [2] = '{8'h00, 8'h00};
    logic [3:0] gprev [2] = '{4'h0, 4'h0};

    serial_bus_arbiter_if #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(8)) b0 ();
    serial_bus_arbiter_if #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(8)) b1 ();
    serial_bus_arbiter #(.NUM_REQ(4), .CLK_DIV(4), .ADDR_W(8), .DATA_W(8)) u0 (.CLK(CLK), .RST(RST), .bus(b0.master));
    serial_bus_arbiter #(.NUM_REQ(4), .CLK_DIV(1), .ADDR_W(8), .DATA_W(8)) u1 (.CLK(CLK), .RST(RST), .bus(b1.master));

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        ntests++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic fail(input string nm);
        ntests++;
        nfail++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // slave model 0: records address bits on SCLK rise, then drives resp[addr] LSB first
    initial begin
        b0.RX = 1'b0;
        forever begin
            @(posedge b0.SCLK or posedge b0.BUSY);
            if (!b0.SCLK) k0 = 0;
            else begin
                if (k0 < 8) cap0[k0[2:0]] = b0.TX;
                else if (k0 < 16) b0.RX = resp[cap0][k0[2:0]];
                k0++;
            end
        end
    end

    // slave model 1
    initial begin
        b1.RX = 1'b0;
        forever begin
            @(posedge b1.SCLK or posedge b1.BUSY);
            if (!b1.SCLK) k1 = 0;
            else begin
                if (k1 < 8) cap1[k1[2:0]] = b1.TX;
                else if (k1 < 16) b1.RX = resp[cap1][k1[2:0]];
                k1++;
            end
        end
    end

    task automatic mon(input int d, input logic [3:0] g, input logic [3:0] dn, input logic [7:0] rd,
                       input logic bsy, input logic [7:0] cp);
        exp_t e;
        chk("gnt_onehot", 32'($onehot0(g)), 1);
        chk("busy_vs_gnt", bsy, |g);
        if (g != 0 && gprev[d] == 0) begin
            gstart[d] = cyc;
            if (q.size() == 0 || q[0].d != d) fail("unexpected_grant");
            else begin
                chk("grant", g, 32'(1) << q[0].idx);
                chk("rd_hold", rd, last_rd[d]);
                if (q[0].b2b) chk("idle_gap", cyc - last_done[d], 2);
            end
        end
        if (dn != 0) begin
            if (q.size() == 0 || q[0].d != d) fail("unexpected_done");
            else begin
                e = q.pop_front();
                chk("done", dn, 32'(1) << e.idx);
                chk("gnt_at_done", g, dn);
                chk("rd_data", rd, e.v);
                chk("tx_addr", cp, e.a);
                chk("latency", cyc - gstart[d], d != 0 ? LAT1 : LAT0);
                last_done[d] = cyc;
                last_rd[d] = e.v;
            end
        end
        gprev[d] = g;
    endtask

    // monitor: compares every DONE and grant against the scoreboard queue
    always @(negedge CLK) begin
        if (RST) begin
            gprev[0] = 4'h0;
            gprev[1] = 4'h0;
        end else begin
            mon(0, b0.GNT, b0.DONE, b0.RD_DATA, b0.BUSY, cap0);
            mon(1, b1.GNT, b1.DONE, b1.RD_DATA, b1.BUSY, cap1);
        end
    end

    function automatic int rr(input int d, input logic [3:0] m);
        int j;
        for (int i = 0; i < 4; i++) begin
            j = (mptr[d] + i) % 4;
            if (m[j[1:0]]) return j;
        end
        return 0;
    endfunction

    task automatic drive(input int d, input logic [3:0] r, input logic [31:0] a);
        if (d == 0) begin
            b0.REQ = r;
            b0.REQ_ADDR = a;
        end else begin
            b1.REQ = r;
            b1.REQ_ADDR = a;
        end
    endtask

    task automatic expect_txn(input int d, input logic [3:0] m, input logic [31:0] a, input bit b2b);
        exp_t e;
        int w;
        w = rr(d, m);
        e.d = d;
        e.idx = w;
        e.a = a[w*8 +: 8];
        e.v = resp[e.a];
        e.b2b = b2b;
        q.push_back(e);
        mptr[d] = (w + 1) % 4;
    endtask

    task automatic wait_done(input int d, input int n);
        int seen;
        int t;
        int lim;
        seen = 0;
        t = 0;
        lim = n * ((d != 0 ? LAT1 : LAT0) + 10) + 20;
        while (seen < n && t < lim) begin
            @(negedge CLK);
            t++;
            if ((d == 0 ? b0.DONE : b1.DONE) != 0) seen++;
        end
        if (seen < n) begin
            fail("done_timeout");
            q.delete();
        end
    endtask

    task automatic run_batch(input int d, input logic [3:0] m, input int n, input logic [31:0] a);
        repeat (2) @(negedge CLK);
        for (int i = 0; i < n; i++) expect_txn(d, m, a, i > 0);
        drive(d, m, a);
        wait_done(d, n);
        drive(d, 4'h0, a);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $display("[TB] %0d tests run, %0d failed", ntests, nfail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int t;
        for (int i = 0; i < 256; i++) resp[i] = 8'($urandom);
        resp[8'hA5] = 8'h3C;
        resp[8'h01] = 8'hFF;
        resp[8'h80] = 8'h01;
        drive(0, 4'h0, 32'h0);
        drive(1, 4'h0, 32'h0);
        #1 RST = 1'b1;
        #2;
        chk("init_gnt", b0.GNT, 0);
        chk("init_busy", b0.BUSY, 0);
        chk("init_sclk", b0.SCLK, 0);
        chk("init_tx", b0.TX, 0);
        chk("init_done", b0.DONE, 0);
        chk("init_rd", b0.RD_DATA, 0);
        chk("init1_gnt", b1.GNT, 0);
        chk("init1_sclk", b1.SCLK, 0);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        run_batch(0, 4'b1111, 8, $urandom);
        run_batch(0, 4'b0011, 2, $urandom);
        a = $urandom;
        a[7:0] = 8'hA5;
        run_batch(0, 4'b0001, 1, a);
        repeat (2) @(negedge CLK);
        a = $urandom;
        a[23:16] = 8'h01;
        expect_txn(0, 4'b0100, a, 1'b0);
        drive(0, 4'b0100, a);
        @(negedge CLK);
        a[23:16] = 8'hFE;
        drive(0, 4'b0000, a);
        wait_done(0, 1);
        repeat (2) @(negedge CLK);
        a = $urandom;
        expect_txn(0, 4'b0010, a, 1'b0);
        drive(0, 4'b0010, a);
        t = 0;
        while (b0.GNT == 0 && t < 10) begin
            @(negedge CLK);
            t++;
        end
        chk("abort_grant", b0.GNT, 4'b0010);
        repeat (92) @(negedge CLK);
        chk("abort_busy", b0.BUSY, 1);
        #3 RST = 1'b1;
        #1;
        chk("rst_gnt", b0.GNT, 0);
        chk("rst_busy", b0.BUSY, 0);
        chk("rst_sclk", b0.SCLK, 0);
        chk("rst_tx", b0.TX, 0);
        chk("rst_done", b0.DONE, 0);
        chk("rst_rd", b0.RD_DATA, 0);
        drive(0, 4'h0, a);
        q.delete();
        mptr[0] = 0;
        mptr[1] = 0;
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        run_batch(0, 4'b1010, 2, $urandom);
        for (int i = 0; i < 12; i++)
            run_batch(0, 4'($urandom_range(1, 15)), $urandom_range(1, 3), $urandom);
        a = $urandom;
        a[7:0] = 8'h80;
        run_batch(1, 4'b0001, 1, a);
        for (int i = 0; i < 5; i++)
            run_batch(1, 4'($urandom_range(1, 15)), $urandom_range(1, 3), $urandom);
        repeat (4) @(negedge CLK);
        chk("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
